// File: rtl/cache_pkg.sv
// Shared definitions for the cache fill controller and the cache data/tag arrays.
package cache_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_t;

    localparam int BLOCK_BYTES     = 16;
    localparam int WORDS_PER_BLOCK = 8;
    localparam int OFFSET_W        = $clog2(BLOCK_BYTES);

endpackage

// File: rtl/word_counter.sv
// Up-counter with synchronous reset, synchronous clear and count enable.
module word_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: issues one read per block word back-to-back,
// writes each returning word into the data array, then writes the tag.
module cache_fill_fsm #(
    parameter int ADDR_W          = 16,
    parameter int WORDS_PER_BLOCK = cache_pkg::WORDS_PER_BLOCK,
    localparam int IDX_W          = $clog2(WORDS_PER_BLOCK),
    localparam int CNT_W          = IDX_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic [15:0]       memory_data,
    input  logic              memory_data_valid,
    output logic              fsm_busy,
    output logic              mem_read_en,
    output logic [ADDR_W-1:0] memory_address,
    output logic              write_data_array,
    output logic [IDX_W-1:0]  data_word_offset,
    output logic [15:0]       data_out,
    output logic              write_tag_array
);

    cache_pkg::fill_state_t r_state;
    cache_pkg::fill_state_t w_next_state;

    logic [ADDR_W-1:0] r_base;
    logic [CNT_W-1:0]  w_issue_cnt;
    logic [CNT_W-1:0]  w_recv_cnt;
    logic              w_clr;
    logic              w_issue_en;
    logic              w_recv_en;
    logic              w_base_load;
    logic              w_issue_active;
    logic              w_last_word;

    // Valid/ready note: memory has no backpressure; a request is accepted the
    // cycle mem_read_en is high, and every memory_data_valid pulse is consumed.
    assign w_issue_active = (w_issue_cnt < CNT_W'(WORDS_PER_BLOCK));
    assign w_last_word    = (w_recv_cnt == CNT_W'(WORDS_PER_BLOCK - 1));

    word_counter #(.W(CNT_W)) u_issue_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_clr),
        .i_en    (w_issue_en),
        .o_count (w_issue_cnt)
    );

    word_counter #(.W(CNT_W)) u_recv_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_clr),
        .i_en    (w_recv_en),
        .o_count (w_recv_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= cache_pkg::IDLE;
            r_base  <= '0;
        end else begin
            r_state <= w_next_state;
            // Word offset plus byte offset are cleared so the base is block aligned.
            if (w_base_load) begin
                r_base <= {miss_address[ADDR_W-1:IDX_W+1], {(IDX_W+1){1'b0}}};
            end
        end
    end

    always_comb begin
        w_next_state     = r_state;
        w_clr            = 1'b0;
        w_issue_en       = 1'b0;
        w_recv_en        = 1'b0;
        w_base_load      = 1'b0;
        fsm_busy         = 1'b0;
        mem_read_en      = 1'b0;
        memory_address   = '0;
        write_data_array = 1'b0;
        data_word_offset = '0;
        data_out         = '0;
        write_tag_array  = 1'b0;
        case (r_state)
            cache_pkg::IDLE: begin
                if (miss_detected) begin
                    w_next_state = cache_pkg::FILL;
                    w_clr        = 1'b1;
                    w_base_load  = 1'b1;
                end
            end
            cache_pkg::FILL: begin
                fsm_busy = 1'b1;
                if (w_issue_active) begin
                    mem_read_en    = 1'b1;
                    memory_address = r_base + ADDR_W'({w_issue_cnt[IDX_W-1:0], 1'b0});
                    w_issue_en     = 1'b1;
                end
                if (memory_data_valid) begin
                    write_data_array = 1'b1;
                    data_word_offset = w_recv_cnt[IDX_W-1:0];
                    data_out         = memory_data;
                    w_recv_en        = 1'b1;
                    if (w_last_word) begin
                        write_tag_array = 1'b1;
                        w_next_state    = cache_pkg::IDLE;
                    end
                end
            end
            default: w_next_state = cache_pkg::IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Randomized and directed bench for cache_fill_fsm against a cycle-indexed model.
module tb_cache_fill_fsm;

    localparam int WPB         = 8;
    localparam int MEM_LATENCY = 4;
    localparam int PLAN_MAX    = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        miss_detected = 1'b0;
    logic [15:0] miss_address = '0;
    logic [15:0] memory_data = '0;
    logic        memory_data_valid = 1'b0;
    logic        fsm_busy;
    logic        mem_read_en;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [2:0]  data_word_offset;
    logic [15:0] data_out;
    logic        write_tag_array;

    cache_fill_fsm #(.ADDR_W(16), .WORDS_PER_BLOCK(WPB)) dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data       (memory_data),
        .memory_data_valid (memory_data_valid),
        .fsm_busy          (fsm_busy),
        .mem_read_en       (mem_read_en),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .data_word_offset  (data_word_offset),
        .data_out          (data_out),
        .write_tag_array   (write_tag_array)
    );

    always #5 clk = ~clk;

    // Stimulus plan, indexed by cycle relative to the start of a test.
    logic        plan_rst   [PLAN_MAX];
    logic        plan_miss  [PLAN_MAX];
    logic [15:0] plan_addr  [PLAN_MAX];
    logic        plan_valid [PLAN_MAX];
    logic [15:0] plan_data  [PLAN_MAX];

    logic        rec_busy [PLAN_MAX];
    logic        rec_rd   [PLAN_MAX];
    logic [15:0] rec_addr [PLAN_MAX];
    logic        rec_wr   [PLAN_MAX];
    logic [2:0]  rec_off  [PLAN_MAX];
    logic [15:0] rec_dout [PLAN_MAX];
    logic        rec_tag  [PLAN_MAX];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Model: a fill is described by its base, the cycle its requests start,
    // and how many words have come back so far.
    bit          m_known = 0;
    bit          m_busy  = 0;
    logic [15:0] m_base  = '0;
    int          m_start = 0;
    int          m_recv  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    task automatic clear_plan();
        for (int i = 0; i < PLAN_MAX; i++) begin
            plan_rst[i]   = 1'b0;
            plan_miss[i]  = 1'b0;
            plan_addr[i]  = 16'($urandom);
            plan_valid[i] = 1'b0;
            plan_data[i]  = 16'($urandom);
        end
    endtask

    task automatic model_check();
        int          idx;
        logic        e_rd;
        logic [15:0] e_addr;
        logic        e_wr;
        idx    = cyc - m_start;
        e_rd   = m_busy && (idx < WPB);
        e_addr = e_rd ? m_base + 16'(2 * idx) : 16'h0;
        e_wr   = m_busy && memory_data_valid;
        chk("busy", 32'(fsm_busy), 32'(m_busy));
        chk("read_en", 32'(mem_read_en), 32'(e_rd));
        if (e_rd || !m_busy) chk("address", 32'(memory_address), 32'(e_addr));
        chk("write_data", 32'(write_data_array), 32'(e_wr));
        if (e_wr || !m_busy) begin
            chk("offset", 32'(data_word_offset), e_wr ? 32'(m_recv) : 32'h0);
            chk("data_out", 32'(data_out), e_wr ? 32'(memory_data) : 32'h0);
        end
        chk("write_tag", 32'(write_tag_array), 32'(e_wr && (m_recv == WPB - 1)));
    endtask

    task automatic model_step();
        if (rst) begin
            m_known = 1;
            m_busy  = 0;
        end else if (!m_busy) begin
            if (miss_detected) begin
                m_busy  = 1;
                m_base  = miss_address & 16'hFFF0;
                m_start = cyc + 1;
                m_recv  = 0;
            end
        end else if (memory_data_valid) begin
            m_recv++;
            if (m_recv == WPB) m_busy = 0;
        end
    endtask

    task automatic run_plan(input int len);
        for (int k = 0; k < len; k++) begin
            @(posedge clk);
            #1;
            rst               = plan_rst[k];
            miss_detected     = plan_miss[k];
            miss_address      = plan_miss[k] ? plan_addr[k] : 16'($urandom);
            memory_data_valid = plan_valid[k];
            memory_data       = plan_data[k];
            @(negedge clk);
            rec_busy[k] = fsm_busy;
            rec_rd[k]   = mem_read_en;
            rec_addr[k] = memory_address;
            rec_wr[k]   = write_data_array;
            rec_off[k]  = data_word_offset;
            rec_dout[k] = data_out;
            rec_tag[k]  = write_tag_array;
            if (m_known) model_check();
            model_step();
            cyc++;
        end
    endtask

    initial begin
        int t;
        int last;

        // Reset, then idle valid noise.
        clear_plan();
        plan_rst[0] = 1'b1;
        plan_rst[1] = 1'b1;
        for (int i = 2; i < 10; i++) plan_valid[i] = 1'($urandom_range(0, 1));
        run_plan(10);
        chk("reset_busy", 32'(rec_busy[2]), 32'h0);
        chk("reset_wr", 32'(rec_wr[9] | rec_wr[2]), 32'h0);

        // Basic fill at nominal latency.
        clear_plan();
        plan_miss[0] = 1'b1;
        plan_addr[0] = 16'h1234;
        for (int i = 0; i < WPB; i++) begin
            plan_valid[1 + MEM_LATENCY + i] = 1'b1;
            plan_data[1 + MEM_LATENCY + i]  = 16'hA000 + 16'(i);
        end
        run_plan(15);
        chk("t1_busy0", 32'(rec_busy[0]), 32'h0);
        chk("t1_busy1", 32'(rec_busy[1]), 32'h1);
        chk("t1_addr1", 32'(rec_addr[1]), 32'h1230);
        chk("t1_addr8", 32'(rec_addr[8]), 32'h123E);
        chk("t1_rd9", 32'(rec_rd[9]), 32'h0);
        chk("t1_dout5", 32'(rec_dout[5]), 32'hA000);
        chk("t1_off12", 32'(rec_off[12]), 32'h7);
        chk("t1_tag11", 32'(rec_tag[11]), 32'h0);
        chk("t1_tag12", 32'(rec_tag[12]), 32'h1);
        chk("t1_busy12", 32'(rec_busy[12]), 32'h1);
        chk("t1_busy13", 32'(rec_busy[13]), 32'h0);

        // Address at the top of memory.
        clear_plan();
        plan_miss[0] = 1'b1;
        plan_addr[0] = 16'hFFFF;
        for (int i = 0; i < WPB; i++) plan_valid[5 + i] = 1'b1;
        run_plan(14);
        chk("t2_addr1", 32'(rec_addr[1]), 32'hFFF0);
        chk("t2_addr8", 32'(rec_addr[8]), 32'hFFFE);

        // Miss during fill is ignored; re-presented miss starts a new fill.
        clear_plan();
        plan_miss[0] = 1'b1;
        plan_addr[0] = 16'h2000;
        plan_miss[3] = 1'b1;
        plan_addr[3] = 16'h4000;
        plan_miss[13] = 1'b1;
        plan_addr[13] = 16'h4000;
        for (int i = 0; i < WPB; i++) begin
            plan_valid[5 + i]  = 1'b1;
            plan_valid[18 + i] = 1'b1;
        end
        run_plan(27);
        chk("t3_addr4", 32'(rec_addr[4]), 32'h2006);
        chk("t3_busy13", 32'(rec_busy[13]), 32'h0);
        chk("t3_busy14", 32'(rec_busy[14]), 32'h1);
        chk("t3_addr14", 32'(rec_addr[14]), 32'h4000);

        // Memory gaps: valid every other cycle.
        clear_plan();
        plan_miss[0] = 1'b1;
        plan_addr[0] = 16'h3456;
        for (int i = 0; i < WPB; i++) plan_valid[5 + 2 * i] = 1'b1;
        run_plan(22);
        chk("t4_off13", 32'(rec_off[13]), 32'h4);
        chk("t4_tag19", 32'(rec_tag[19]), 32'h1);
        chk("t4_busy20", 32'(rec_busy[20]), 32'h0);

        // Reset mid-fill, late valids ignored, then a clean fill.
        clear_plan();
        plan_miss[0] = 1'b1;
        plan_addr[0] = 16'h5550;
        plan_rst[6]  = 1'b1;
        plan_miss[14] = 1'b1;
        plan_addr[14] = 16'h6660;
        for (int i = 0; i < WPB; i++) begin
            plan_valid[5 + i]  = 1'b1;
            plan_valid[19 + i] = 1'b1;
        end
        run_plan(30);
        chk("t5_busy7", 32'(rec_busy[7]), 32'h0);
        chk("t5_wr8", 32'(rec_wr[8]), 32'h0);
        chk("t5_wr19", 32'(rec_wr[19]), 32'h1);
        chk("t5_off19", 32'(rec_off[19]), 32'h0);

        // Randomized fills with gaps, ignored misses and trailing idle noise.
        for (int r = 0; r < 20; r++) begin
            clear_plan();
            plan_miss[0] = 1'b1;
            t = 1 + MEM_LATENCY;
            for (int i = 0; i < WPB; i++) begin
                t += $urandom_range(0, 2);
                plan_valid[t] = 1'b1;
                t++;
            end
            last = t - 1;
            for (int j = 1; j <= last; j++) plan_miss[j] = ($urandom_range(0, 3) == 0);
            for (int j = last + 1; j < last + 7; j++) plan_valid[j] = 1'($urandom_range(0, 1));
            run_plan(last + 7);
            chk("rnd_tag", 32'(rec_tag[last]), 32'h1);
            chk("rnd_idle", 32'(rec_busy[last + 1]), 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
Miss-handling controller between the processor's caches and the 4-cycle pipelined main memory. When the I-cache or D-cache signals a miss, it issues one read per word of the 16-byte block on consecutive cycles. It steers each returning word into the cache data array, then writes the tag. While busy it holds the pipeline stall asserted; one instance sits in front of each cache.

Parameters:
ADDR_W, 16, byte-address width
WORDS_PER_BLOCK, 8, 16-bit words per cache block; must be a power of 2, at least 2
MEM_LATENCY, 4, nominal cycles from memory_address issue to memory_data_valid; bench use only, the RTL counts valids

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
miss_detected  input  1  cache miss this cycle; sampled only in IDLE
miss_address  input  ADDR_W  byte address of the missing access
memory_data  input  16  word returned by main memory
memory_data_valid  input  1  memory_data valid this cycle
fsm_busy  output  1  fill in progress (state != IDLE); ORed externally into the stall
mem_read_en  output  1  read request to main memory this cycle
memory_address  output  ADDR_W  word address of the current read request
write_data_array  output  1  write memory_data into the data array at data_word_offset
data_word_offset  output  log2(WORDS_PER_BLOCK)  word index within the block for the current write
data_out  output  16  memory_data passed through, aligned with write_data_array
write_tag_array  output  1  write tag/valid for the block being filled

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE, issue_cnt=0, recv_cnt=0, block base=0. All outputs are 0 from the following cycle. A fill in flight is abandoned silently; late memory_data_valid pulses arrive in IDLE and are ignored.
- State IDLE: all outputs 0. If miss_detected=1:
  - latch base = miss_address with the low log2(WORDS_PER_BLOCK)+1 bits cleared;
  - clear both counters;
  - move to FILL at the next edge.
  - Latency: fsm_busy rises the cycle after the miss.
- State FILL, issue side:
  - while issue_cnt < WORDS_PER_BLOCK: mem_read_en=1 and memory_address = base + 2*issue_cnt; issue_cnt increments every cycle.
  - Issue never stalls, giving exactly WORDS_PER_BLOCK consecutive requests.
- State FILL, receive side: on memory_data_valid=1:
  - write_data_array=1, data_word_offset=recv_cnt, data_out=memory_data, all combinational in the same cycle;
  - recv_cnt increments.
  - Issue and receive may overlap in the same cycle; the counters are independent.
- Completion: when memory_data_valid=1 and recv_cnt=WORDS_PER_BLOCK-1:
  - write_tag_array=1 in the same cycle as the final data write;
  - state returns to IDLE at the next edge.
  - fsm_busy is still 1 in the completion cycle.
- Nominal timing (latency 4, 8 words), miss at cycle 0:
  - busy cycles 1–12;
  - requests in cycles 1–8, returns in cycles 5–12;
  - tag write in cycle 12;
  - IDLE in cycle 13, so a new miss is accepted in cycle 13.
- miss_detected while in FILL is ignored; miss_address changes during FILL have no effect.
- Gaps in memory_data_valid are tolerated: the FSM waits in FILL indefinitely.
- Valid pulses beyond WORDS_PER_BLOCK cannot occur in FILL (the FSM exits on the last one) and are ignored in IDLE.
- Address arithmetic wraps modulo 2^ADDR_W. Because base is block-aligned, base + 2*issue_cnt never carries out of the block.
- Counter width: log2(WORDS_PER_BLOCK)+1 bits, so the issue-done condition (issue_cnt == WORDS_PER_BLOCK) is representable.

Decomposition:
- Package cache_pkg holds:
  - fill_state_t enum {IDLE, FILL};
  - BLOCK_BYTES=16, WORDS_PER_BLOCK=8;
  - OFFSET_W = log2(BLOCK_BYTES).
  - It is shared with the cache data and tag arrays.
- Sub-module word_counter (synchronous clear, enable, count output) is instanced twice: once for issue_cnt and once for recv_cnt.

Test Plan:
1. Basic fill: miss_address=0x1234, memory returns 0xA000+i at latency 4 → requests 0x1230, 0x1232, …, 0x123E in cycles 1–8; data writes offsets 0–7 with 0xA000–0xA007 in cycles 5–12; write_tag_array only in cycle 12; fsm_busy high exactly cycles 1–12.
2. Wrap address: miss_address=0xFFFF → requests 0xFFF0–0xFFFE, no carry into upper bits.
3. Miss during fill: a second miss_detected with address 0x4000 at cycle 3 → no requests to 0x4000; a new miss at cycle 13 starts a fill of 0x4000, busy from cycle 14.
4. Memory gaps: valid pulses at cycles 5, 7, 9, …, 19 → offsets 0–7 written in order; tag write at cycle 19; IDLE at cycle 20.
5. Reset mid-fill: rst=1 at cycle 6 → all outputs 0 from cycle 7; remaining valid pulses produce no writes; next miss starts cleanly at offset 0.
6. Idle noise: memory_data_valid pulses with no miss pending → no array writes, fsm_busy stays 0.
